// File: rtl/i2s_pkg.sv
// Shared I2S constants: default word width and status-register bit positions
// so every flags register packs FIFO status the same way.
package i2s_pkg;

   localparam int I2S_DATA_W = 32;

   localparam int FL_FULL   = 0;
   localparam int FL_EMPTY  = 1;
   localparam int FL_AFULL  = 2;
   localparam int FL_AEMPTY = 3;
   localparam int FL_OVF    = 4;
   localparam int FL_UDF    = 5;
   localparam int FL_W      = 6;

   typedef logic [FL_W-1:0] flags_t;

   function automatic flags_t pack_flags(input logic full, input logic empty,
                                         input logic afull, input logic aempty,
                                         input logic ovf, input logic udf);
      flags_t f;
      f            = '0;
      f[FL_FULL]   = full;
      f[FL_EMPTY]  = empty;
      f[FL_AFULL]  = afull;
      f[FL_AEMPTY] = aempty;
      f[FL_OVF]    = ovf;
      f[FL_UDF]    = udf;
      return f;
   endfunction

endpackage

// File: rtl/i2s_tx_fifo_if.sv
// Bus between the TX register/control logic (master) and the TX FIFO (slave).
interface i2s_tx_fifo_if #(
   parameter int DATA_W = i2s_pkg::I2S_DATA_W,
   parameter int LVL_W  = 4
);
   // Strobes are plain one-per-cycle requests: wen/ren each move at most one
   // word per rising edge, and rvalid pulses one cycle after an accepted ren.
   logic              flush;
   logic              wen;
   logic [DATA_W-1:0] wdata;
   logic              ren;
   logic              err_clr;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [LVL_W-1:0]  level;
   logic              overflow;
   logic              underflow;

   modport master (
      output flush, wen, wdata, ren, err_clr,
      input  rdata, rvalid, full, empty, almost_full, almost_empty, level,
             overflow, underflow
   );

   modport slave (
      input  flush, wen, wdata, ren, err_clr,
      output rdata, rvalid, full, empty, almost_full, almost_empty, level,
             overflow, underflow
   );
endinterface

// File: rtl/i2s_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array, synchronous write, registered read.
// The array itself is not reset; only the read register is.
module i2s_fifo_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                     pclk,
   input  logic                     preset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge pclk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset)  rdata <= '0;
      else if (re)  rdata <= mem[raddr];
   end

endmodule

// File: rtl/i2s_tx_fifo.sv
// TX sample FIFO between the APB data register and the I2S serializer.
// Optional sticky overflow/underflow flags: define I2S_FIFO_ERR_FLAGS_EN.
module i2s_tx_fifo
   import i2s_pkg::*;
#(
   parameter int DATA_W = I2S_DATA_W,
   parameter int DEPTH  = 8,
   parameter int AF_LVL = 6,
   parameter int AE_LVL = 2
) (
   input  logic        pclk,
   input  logic        preset,
   i2s_tx_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AF_L = PW'(AF_LVL);
   localparam logic [PW-1:0] AE_L = PW'(AE_LVL);

   generate
      if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
          !(AE_LVL < AF_LVL && AF_LVL <= DEPTH)) begin : g_bad_cfg
         $error("i2s_tx_fifo: bad DEPTH/AF_LVL/AE_LVL configuration");
      end
   endgenerate

   logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, lvl_nxt;
   logic          wr_ok, rd_ok;

   // full/empty are the registered pre-cycle state, so a full+read cycle
   // still drops the write and an empty+write cycle still underflows the read.
   assign wr_ok = bus.wen && !bus.full  && !bus.flush;
   assign rd_ok = bus.ren && !bus.empty && !bus.flush;

   always_comb begin
      wr_nxt = wr_ptr;
      rd_nxt = rd_ptr;
      if (bus.flush) begin
         wr_nxt = '0;
         rd_nxt = '0;
      end else begin
         if (wr_ok) wr_nxt = wr_ptr + 1'b1;
         if (rd_ok) rd_nxt = rd_ptr + 1'b1;
      end
      lvl_nxt = wr_nxt - rd_nxt;
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         bus.level        <= '0;
         bus.full         <= 1'b0;
         bus.empty        <= 1'b1;
         bus.almost_full  <= 1'b0;
         bus.almost_empty <= 1'b1;
         bus.rvalid       <= 1'b0;
      end else begin
         wr_ptr           <= wr_nxt;
         rd_ptr           <= rd_nxt;
         bus.level        <= lvl_nxt;
         bus.full         <= (wr_nxt[AW] != rd_nxt[AW]) &&
                             (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
         bus.empty        <= (wr_nxt == rd_nxt);
         bus.almost_full  <= (lvl_nxt >= AF_L);
         bus.almost_empty <= (lvl_nxt <= AE_L);
         bus.rvalid       <= rd_ok;
      end
   end

   i2s_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
      .pclk   (pclk),
      .preset (preset),
      .we     (wr_ok),
      .waddr  (wr_ptr[AW-1:0]),
      .wdata  (bus.wdata),
      .re     (rd_ok),
      .raddr  (rd_ptr[AW-1:0]),
      .rdata  (bus.rdata)
   );

`ifdef I2S_FIFO_ERR_FLAGS_EN
   logic ovf_set, udf_set;
   assign ovf_set = bus.wen && bus.full  && !bus.flush;
   assign udf_set = bus.ren && bus.empty && !bus.flush;

   // A set event in the same cycle as err_clr wins.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         bus.overflow  <= 1'b0;
         bus.underflow <= 1'b0;
      end else begin
         if (ovf_set)          bus.overflow  <= 1'b1;
         else if (bus.err_clr) bus.overflow  <= 1'b0;
         if (udf_set)          bus.underflow <= 1'b1;
         else if (bus.err_clr) bus.underflow <= 1'b0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.overflow   = 1'b0;
   assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Bench for i2s_tx_fifo: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_i2s_tx_fifo;
   import i2s_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int LW    = 4;
   localparam int AF    = 6;
   localparam int AE    = 2;
`ifdef I2S_FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic pclk   = 1'b0;
   logic preset = 1'b0;
   always #5 pclk = ~pclk;

   i2s_tx_fifo_if #(.DATA_W(DW), .LVL_W(LW)) bus ();

   i2s_tx_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE)) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   bit done  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of words plus the last word read out.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_rdata  = '0;
   logic          m_rvalid = 1'b0;
   logic          m_ovf    = 1'b0;
   logic          m_udf    = 1'b0;
   bit            was_full, was_empty;

   always @(posedge pclk or negedge preset) begin
      if (!preset) begin
         mq.delete();
         m_rdata  = '0;
         m_rvalid = 1'b0;
         m_ovf    = 1'b0;
         m_udf    = 1'b0;
      end else begin
         m_rvalid  = 1'b0;
         was_full  = (mq.size() == DEPTH);
         was_empty = (mq.size() == 0);
         if (bus.err_clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
         end
         if (bus.flush) begin
            mq.delete();
         end else begin
            if (bus.ren) begin
               if (!was_empty) begin
                  m_rdata  = mq.pop_front();
                  m_rvalid = 1'b1;
               end else if (ERR_EN) m_udf = 1'b1;
            end
            if (bus.wen) begin
               if (!was_full) mq.push_back(bus.wdata);
               else if (ERR_EN) m_ovf = 1'b1;
            end
         end
      end
   end

   always @(negedge pclk) begin
      if (!done) begin
         chk("m_level",  32'(bus.level),        32'(mq.size()));
         chk("m_full",   32'(bus.full),         32'(mq.size() == DEPTH));
         chk("m_empty",  32'(bus.empty),        32'(mq.size() == 0));
         chk("m_afull",  32'(bus.almost_full),  32'(mq.size() >= AF));
         chk("m_aempty", 32'(bus.almost_empty), 32'(mq.size() <= AE));
         chk("m_rvalid", 32'(bus.rvalid),       32'(m_rvalid));
         chk("m_rdata",  bus.rdata,             m_rdata);
         chk("m_ovf",    32'(bus.overflow),     32'(m_ovf));
         chk("m_udf",    32'(bus.underflow),    32'(m_udf));
      end
   end

   // Apply one cycle of strobes, then return #1 after the edge with strobes idle.
   task automatic drive(input logic w, input logic [DW-1:0] wd, input logic r,
                        input logic f, input logic ec);
      bus.wen = w; bus.wdata = wd; bus.ren = r; bus.flush = f; bus.err_clr = ec;
      @(posedge pclk);
      #1;
      bus.wen = 1'b0; bus.ren = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;
   endtask

   task automatic summary();
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      summary();
      $finish;
   end

   initial begin
      bus.wen = 1'b0; bus.wdata = '0; bus.ren = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;
      repeat (3) @(posedge pclk);
      #1 preset = 1'b1;

      // Reset then idle
      for (int i = 0; i < 5; i++) begin
         drive(0, '0, 0, 0, 0);
         chk("rst_empty",  32'(bus.empty), 32'd1);
         chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
         chk("rst_level",  32'(bus.level), 32'd0);
         chk("rst_rdata",  bus.rdata, 32'd0);
         chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
      end

      // Fill to full, then one extra write
      for (int i = 0; i < 8; i++) begin
         drive(1, 32'h1000_0000 + i, 0, 0, 0);
         chk("fill_level", 32'(bus.level), 32'(i + 1));
         chk("fill_afull", 32'(bus.almost_full), 32'((i + 1) >= 6));
         chk("fill_full",  32'(bus.full), 32'(i == 7));
      end
      drive(1, 32'hDEAD_BEEF, 0, 0, 0);
      chk("ovf_level", 32'(bus.level), 32'd8);
      chk("ovf_flag",  32'(bus.overflow), 32'(ERR_EN));

      // Drain in order
      for (int i = 0; i < 8; i++) begin
         drive(0, '0, 1, 0, 0);
         chk("drain_rvalid", 32'(bus.rvalid), 32'd1);
         chk("drain_rdata",  bus.rdata, 32'h1000_0000 + i);
      end
      chk("drain_empty", 32'(bus.empty), 32'd1);
      drive(0, '0, 1, 0, 0);
      chk("udf_rvalid", 32'(bus.rvalid), 32'd0);
      chk("udf_rdata",  bus.rdata, 32'h1000_0007);
      chk("udf_flag",   32'(bus.underflow), 32'(ERR_EN));
      drive(0, '0, 0, 0, 1);
      chk("clr_ovf", 32'(bus.overflow), 32'd0);
      chk("clr_udf", 32'(bus.underflow), 32'd0);

      // Pointer wrap with level held at 3
      for (int k = 0; k < 3; k++) drive(1, 32'hA000_0000 + k, 0, 0, 0);
      for (int k = 0; k < 20; k++) begin
         drive(1, 32'hA000_0000 + k + 3, 1, 0, 0);
         chk("wrap_level", 32'(bus.level), 32'd3);
         chk("wrap_rdata", bus.rdata, 32'hA000_0000 + k);
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, '0, 1, 0, 0);
         chk("wrap_tail", bus.rdata, 32'hA000_0000 + 20 + k);
      end

      // wen+ren at full: read proceeds, write dropped
      for (int i = 0; i < 8; i++) drive(1, 32'hB000_0000 + i, 0, 0, 0);
      drive(1, 32'hCAFE_F00D, 1, 0, 0);
      chk("sim_full_level", 32'(bus.level), 32'd7);
      chk("sim_full_rdata", bus.rdata, 32'hB000_0000);
      chk("sim_full_ovf",   32'(bus.overflow), 32'(ERR_EN));
      for (int i = 0; i < 7; i++) begin
         drive(0, '0, 1, 0, 0);
         chk("sim_full_drain", bus.rdata, 32'hB000_0001 + i);
      end

      // wen+ren at empty: write lands, read underflows
      drive(1, 32'hC0DE_0001, 1, 0, 0);
      chk("sim_empty_level",  32'(bus.level), 32'd1);
      chk("sim_empty_rvalid", 32'(bus.rvalid), 32'd0);
      chk("sim_empty_udf",    32'(bus.underflow), 32'(ERR_EN));
      drive(0, '0, 0, 0, 1);

      // flush+wen at level 4
      for (int i = 0; i < 3; i++) drive(1, 32'hD000_0000 + i, 0, 0, 0);
      chk("pre_flush_level", 32'(bus.level), 32'd4);
      drive(1, 32'hEEEE_EEEE, 0, 1, 0);
      chk("flush_level", 32'(bus.level), 32'd0);
      chk("flush_empty", 32'(bus.empty), 32'd1);
      chk("flush_rdata", bus.rdata, 32'hB000_0007);

      // Async reset at level 5 with a write pending
      for (int i = 0; i < 5; i++) drive(1, 32'h5000_0000 + i, 0, 0, 0);
      bus.wen = 1'b1; bus.wdata = 32'h5000_00FF;
      #3 preset = 1'b0;
      #1;
      chk("arst_level",  32'(bus.level), 32'd0);
      chk("arst_empty",  32'(bus.empty), 32'd1);
      chk("arst_aempty", 32'(bus.almost_empty), 32'd1);
      chk("arst_full",   32'(bus.full), 32'd0);
      chk("arst_afull",  32'(bus.almost_full), 32'd0);
      chk("arst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("arst_rdata",  bus.rdata, 32'd0);
      bus.wen = 1'b0;
      @(posedge pclk);
      #1 preset = 1'b1;
      drive(1, 32'h6000_0001, 0, 0, 0);
      chk("post_rst_level", 32'(bus.level), 32'd1);
      drive(0, '0, 1, 0, 0);
      chk("post_rst_rvalid", 32'(bus.rvalid), 32'd1);
      chk("post_rst_rdata",  bus.rdata, 32'h6000_0001);

      repeat (3) drive(0, '0, 0, 0, 0);
      summary();
      $finish;
   end

endmodule
